// File: rtl/vx_tensor_operand_responder.sv
// Tensor operand responder: a single-port operand buffer that is filled by a
// producer and read by two independent request/response channels (A and B).
// Each channel owns a small response queue. Request acceptance is limited by
// the free space in that queue, so the queue can never overflow.

// Per-channel response queue: circular buffer with occupancy count
module vx_tensor_operand_respq #(
  parameter int W      = 8,
  parameter int QDEPTH = 2
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  logic [W-1:0]  slots_q [QDEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next pointer and occupancy values; a simultaneous push and pop leaves the count unchanged
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop_i) begin
      rd_ptr_d = (rd_ptr_q == PW'(QDEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    if (push_i) begin
      wr_ptr_d = (wr_ptr_q == PW'(QDEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (push_i && !pop_i) begin
      count_d = count_q + CW'(1);
    end else if (!push_i && pop_i) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointer and occupancy state; reset discards every queued entry
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; stale slots are unreachable once the count is cleared
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      slots_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CW'(QDEPTH));
  assign data_o  = slots_q[rd_ptr_q];

  // Upstream credit logic must never push into a full queue
  push_when_full_a : assert property (@(posedge clk_i) disable iff (reset_i) !(push_i && full_o));

endmodule

// Top level: fill port, arbitration between the A and B readers, and response queues
module vx_tensor_operand_responder #(
  parameter int DATAW       = 256,
  parameter int SRCW        = 2,
  parameter int ADDRW       = 32,
  parameter int DEPTH       = 256,
  parameter int RESPQ_DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     fill_valid_i,
  input  logic [$clog2(DEPTH)-1:0] fill_addr_i,
  input  logic [DATAW-1:0]         fill_data_i,
  input  logic                     reqA_valid_i,
  output logic                     reqA_ready_o,
  input  logic [SRCW-1:0]          reqA_source_i,
  input  logic [ADDRW-1:0]         reqA_address_i,
  output logic                     respA_valid_o,
  input  logic                     respA_ready_i,
  output logic [SRCW-1:0]          respA_source_o,
  output logic [DATAW-1:0]         respA_data_o,
  input  logic                     reqB_valid_i,
  output logic                     reqB_ready_o,
  input  logic [SRCW-1:0]          reqB_source_i,
  input  logic [ADDRW-1:0]         reqB_address_i,
  output logic                     respB_valid_o,
  input  logic                     respB_ready_i,
  output logic [SRCW-1:0]          respB_source_o,
  output logic [DATAW-1:0]         respB_data_o
);

  localparam int IDXW = $clog2(DEPTH);
  localparam int OFFW = $clog2(DATAW / 8);
  localparam int ENTW = SRCW + DATAW;

  logic [DATAW-1:0] buffer_q [DEPTH];

  logic [IDXW-1:0]  idx_a, idx_b, rd_idx;
  logic [DATAW-1:0] rd_word;
  logic             full_a, full_b;
  logic             elig_a, elig_b;
  logic             ready_a, ready_b;
  logic             fire_a, fire_b;
  logic             pop_a, pop_b;
  logic             rr_q, rr_d;
  logic [ENTW-1:0]  entry_a, entry_b;
  logic             unused_addr_bits;

  // Byte offset inside a word and address bits above the buffer are ignored
  assign idx_a = reqA_address_i[OFFW +: IDXW];
  assign idx_b = reqB_address_i[OFFW +: IDXW];
  assign unused_addr_bits = ^{reqA_address_i, reqB_address_i};

  // Grant logic: fill owns the port; otherwise a channel with credit is granted
  // unless the other channel is eligible and the round-robin pointer favours it.
  // A channel's own valid is deliberately kept out of its own ready.
  always_comb begin
    elig_a  = reqA_valid_i && !full_a && !fill_valid_i;
    elig_b  = reqB_valid_i && !full_b && !fill_valid_i;
    ready_a = !fill_valid_i && !full_a && (!elig_b || !rr_q);
    ready_b = !fill_valid_i && !full_b && (!elig_a || rr_q);
    fire_a  = reqA_valid_i && ready_a;
    fire_b  = reqB_valid_i && ready_b;
    rr_d    = (fire_a || fire_b) ? !rr_q : rr_q;
  end

  assign reqA_ready_o = ready_a;
  assign reqB_ready_o = ready_b;

  // Round-robin pointer flips after every accepted read
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

  // Operand buffer write port; contents survive reset
  always_ff @(posedge clk_i) begin
    if (fill_valid_i) begin
      buffer_q[fill_addr_i] <= fill_data_i;
    end
  end

  // The single read port is steered to whichever channel won. The word is read
  // in the acceptance cycle and pushed straight into the response queue, so
  // nothing is ever in flight outside the queues and credits equal occupancy.
  assign rd_idx  = fire_b ? idx_b : idx_a;
  assign rd_word = buffer_q[rd_idx];

  assign pop_a = respA_valid_o && respA_ready_i;
  assign pop_b = respB_valid_o && respB_ready_i;

  vx_tensor_operand_respq #(
    .W      (ENTW),
    .QDEPTH (RESPQ_DEPTH)
  ) u_respq_a (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (fire_a),
    .push_data_i ({reqA_source_i, rd_word}),
    .pop_i       (pop_a),
    .valid_o     (respA_valid_o),
    .full_o      (full_a),
    .data_o      (entry_a)
  );

  vx_tensor_operand_respq #(
    .W      (ENTW),
    .QDEPTH (RESPQ_DEPTH)
  ) u_respq_b (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (fire_b),
    .push_data_i ({reqB_source_i, rd_word}),
    .pop_i       (pop_b),
    .valid_o     (respB_valid_o),
    .full_o      (full_b),
    .data_o      (entry_b)
  );

  assign {respA_source_o, respA_data_o} = entry_a;
  assign {respB_source_o, respB_data_o} = entry_b;

endmodule
